// File: rtl/dcache_mshr_if.sv
// Bundle of the MSHR's load/store-unit allocation port, its memory request/return port and its cache fill port.
// Handshake: an allocation transfers on a cycle where alloc_valid && alloc_ready; alloc_ready depends only on registered MSHR state.
interface dcache_mshr_if #(
  parameter int ID_WIDTH = 5
);
  logic                alloc_valid;
  logic [31:0]         alloc_addr;
  logic                alloc_is_store;
  logic [1:0]          alloc_st_size;
  logic [31:0]         alloc_data;
  logic [ID_WIDTH-1:0] alloc_id;
  logic                alloc_ready;

  logic [1:0]          proc2mem_command;
  logic [31:0]         proc2mem_addr;
  logic [3:0]          mem2proc_transaction_tag;
  logic [63:0]         mem2proc_data;
  logic [3:0]          mem2proc_data_tag;

  logic                mshr2Dcache_wr;
  logic [63:0]         mshr2Dcache_mem_block;
  logic [31:0]         mshr2Dcache_addr;
  logic                mshr2Dcache_is_store;
  logic [1:0]          mshr2Dcache_st_size;
  logic [31:0]         mshr2Dcache_data;
  logic [ID_WIDTH-1:0] mshr2Dcache_id;
  logic                mshr_empty;

  modport slave (
    input  alloc_valid, alloc_addr, alloc_is_store, alloc_st_size, alloc_data, alloc_id,
    output alloc_ready,
    output proc2mem_command, proc2mem_addr,
    input  mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag,
    output mshr2Dcache_wr, mshr2Dcache_mem_block, mshr2Dcache_addr, mshr2Dcache_is_store,
    output mshr2Dcache_st_size, mshr2Dcache_data, mshr2Dcache_id, mshr_empty
  );

  modport master (
    output alloc_valid, alloc_addr, alloc_is_store, alloc_st_size, alloc_data, alloc_id,
    input  alloc_ready,
    input  proc2mem_command, proc2mem_addr,
    output mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag,
    input  mshr2Dcache_wr, mshr2Dcache_mem_block, mshr2Dcache_addr, mshr2Dcache_is_store,
    input  mshr2Dcache_st_size, mshr2Dcache_data, mshr2Dcache_id, mshr_empty
  );
endinterface

// File: rtl/dcache_mshr.sv
// Miss-status holding registers between the LSU and the data cache: allocate, issue MEM_LOAD, match tags, fill.
// Optional statistics counters are built when DCACHE_MSHR_STATS_EN is defined.
module dcache_mshr #(
  parameter int NUM_ENTRIES = 4,
  parameter int ID_WIDTH    = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  dcache_mshr_if.slave             mif,
  output logic [2*NUM_ENTRIES-1:0] state_dbg_o
`ifdef DCACHE_MSHR_STATS_EN
  ,
  output logic [31:0]              stat_misses,
  output logic [31:0]              stat_full_stalls,
  output logic [31:0]              stat_retries
`endif
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam logic [1:0] MEM_NONE = 2'd0;
  localparam logic [1:0] MEM_LOAD = 2'd1;

  typedef enum logic [1:0] {
    E_FREE    = 2'd0,
    E_PENDING = 2'd1,
    E_WAIT    = 2'd2
  } entry_state_e;

  entry_state_e        state_q    [NUM_ENTRIES];
  entry_state_e        state_d    [NUM_ENTRIES];
  logic [31:0]         addr_q     [NUM_ENTRIES];
  logic [31:0]         addr_d     [NUM_ENTRIES];
  logic                is_store_q [NUM_ENTRIES];
  logic                is_store_d [NUM_ENTRIES];
  logic [1:0]          st_size_q  [NUM_ENTRIES];
  logic [1:0]          st_size_d  [NUM_ENTRIES];
  logic [31:0]         data_q     [NUM_ENTRIES];
  logic [31:0]         data_d     [NUM_ENTRIES];
  logic [ID_WIDTH-1:0] id_q       [NUM_ENTRIES];
  logic [ID_WIDTH-1:0] id_d       [NUM_ENTRIES];
  logic [3:0]          tag_q      [NUM_ENTRIES];
  logic [3:0]          tag_d      [NUM_ENTRIES];

  logic                fill_wr_q, fill_wr_d;
  logic [63:0]         fill_blk_q, fill_blk_d;
  logic [31:0]         fill_addr_q, fill_addr_d;
  logic                fill_st_q, fill_st_d;
  logic [1:0]          fill_size_q, fill_size_d;
  logic [31:0]         fill_data_q, fill_data_d;
  logic [ID_WIDTH-1:0] fill_id_q, fill_id_d;

`ifdef DCACHE_MSHR_STATS_EN
  logic [31:0] misses_q, misses_d;
  logic [31:0] stalls_q, stalls_d;
  logic [31:0] retries_q, retries_d;
`endif

  logic             free_found, pend_found, blk_hit, any_busy;
  logic [IDX_W-1:0] free_idx, pend_idx;
  logic             alloc_fire;

  // Priority scans over registered state only; nothing here looks at this cycle's returns.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    pend_found = 1'b0;
    pend_idx   = '0;
    blk_hit    = 1'b0;
    any_busy   = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (state_q[i] == E_FREE) begin
        if (!free_found) begin
          free_found = 1'b1;
          free_idx   = IDX_W'(i);
        end
      end else begin
        any_busy = 1'b1;
        if (addr_q[i][31:3] == mif.alloc_addr[31:3]) blk_hit = 1'b1;
      end
      if (state_q[i] == E_PENDING && !pend_found) begin
        pend_found = 1'b1;
        pend_idx   = IDX_W'(i);
      end
    end
  end

  assign mif.alloc_ready      = free_found && !blk_hit;
  assign mif.mshr_empty       = !any_busy;
  assign mif.proc2mem_command = pend_found ? MEM_LOAD : MEM_NONE;
  assign mif.proc2mem_addr    = pend_found ? {addr_q[pend_idx][31:3], 3'b000} : 32'd0;
  assign alloc_fire           = mif.alloc_valid && mif.alloc_ready;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    is_store_d = is_store_q;
    st_size_d  = st_size_q;
    data_d     = data_q;
    id_d       = id_q;
    tag_d      = tag_q;
    fill_wr_d   = 1'b0;
    fill_blk_d  = '0;
    fill_addr_d = '0;
    fill_st_d   = 1'b0;
    fill_size_d = '0;
    fill_data_d = '0;
    fill_id_d   = '0;

    // The returning entry is WAIT, so it can never be the issuing or allocating entry.
    if (mif.mem2proc_data_tag != 4'd0) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (state_q[i] == E_WAIT && tag_q[i] == mif.mem2proc_data_tag) begin
          state_d[i]  = E_FREE;
          tag_d[i]    = 4'd0;
          fill_wr_d   = 1'b1;
          fill_blk_d  = mif.mem2proc_data;
          fill_addr_d = addr_q[i];
          fill_st_d   = is_store_q[i];
          fill_size_d = st_size_q[i];
          fill_data_d = data_q[i];
          fill_id_d   = id_q[i];
        end
      end
    end

    if (pend_found && mif.mem2proc_transaction_tag != 4'd0) begin
      state_d[pend_idx] = E_WAIT;
      tag_d[pend_idx]   = mif.mem2proc_transaction_tag;
    end

    if (alloc_fire) begin
      state_d[free_idx]    = E_PENDING;
      addr_d[free_idx]     = mif.alloc_addr;
      is_store_d[free_idx] = mif.alloc_is_store;
      st_size_d[free_idx]  = mif.alloc_st_size;
      data_d[free_idx]     = mif.alloc_data;
      id_d[free_idx]       = mif.alloc_id;
    end
  end

`ifdef DCACHE_MSHR_STATS_EN
  always_comb begin
    misses_d  = misses_q  + (alloc_fire ? 32'd1 : 32'd0);
    stalls_d  = stalls_q  + ((mif.alloc_valid && !mif.alloc_ready) ? 32'd1 : 32'd0);
    retries_d = retries_q + ((pend_found && mif.mem2proc_transaction_tag == 4'd0) ? 32'd1 : 32'd0);
  end

  assign stat_misses      = misses_q;
  assign stat_full_stalls = stalls_q;
  assign stat_retries     = retries_q;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i]    <= E_FREE;
        addr_q[i]     <= '0;
        is_store_q[i] <= 1'b0;
        st_size_q[i]  <= '0;
        data_q[i]     <= '0;
        id_q[i]       <= '0;
        tag_q[i]      <= '0;
      end
      fill_wr_q   <= 1'b0;
      fill_blk_q  <= '0;
      fill_addr_q <= '0;
      fill_st_q   <= 1'b0;
      fill_size_q <= '0;
      fill_data_q <= '0;
      fill_id_q   <= '0;
`ifdef DCACHE_MSHR_STATS_EN
      misses_q  <= '0;
      stalls_q  <= '0;
      retries_q <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i]    <= state_d[i];
        addr_q[i]     <= addr_d[i];
        is_store_q[i] <= is_store_d[i];
        st_size_q[i]  <= st_size_d[i];
        data_q[i]     <= data_d[i];
        id_q[i]       <= id_d[i];
        tag_q[i]      <= tag_d[i];
      end
      fill_wr_q   <= fill_wr_d;
      fill_blk_q  <= fill_blk_d;
      fill_addr_q <= fill_addr_d;
      fill_st_q   <= fill_st_d;
      fill_size_q <= fill_size_d;
      fill_data_q <= fill_data_d;
      fill_id_q   <= fill_id_d;
`ifdef DCACHE_MSHR_STATS_EN
      misses_q  <= misses_d;
      stalls_q  <= stalls_d;
      retries_q <= retries_d;
`endif
    end
  end

  assign mif.mshr2Dcache_wr        = fill_wr_q;
  assign mif.mshr2Dcache_mem_block = fill_blk_q;
  assign mif.mshr2Dcache_addr      = fill_addr_q;
  assign mif.mshr2Dcache_is_store  = fill_st_q;
  assign mif.mshr2Dcache_st_size   = fill_size_q;
  assign mif.mshr2Dcache_data      = fill_data_q;
  assign mif.mshr2Dcache_id        = fill_id_q;

  always_comb begin
    state_dbg_o = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) state_dbg_o[2*i +: 2] = state_q[i];
  end
endmodule

// File: doc/dcache_mshr.md
Name: dcache_mshr

Overview:
- Miss-status holding register file directly upstream of the data cache.
- Accepts load/store misses from the load/store unit and issues block-aligned MEM_LOAD requests to memory.
- Matches memory transaction tags on return and drives the cache fill port (mshr2Dcache_*) for one cycle per completed miss.
- Stores are write-allocate. The fill carries the original store's size and data so the cache merges them on the fill cycle.

Parameters:
- NUM_ENTRIES, 4, number of outstanding misses (power of two, ≥2).
- ID_WIDTH, 5, width of the requester id returned with each fill (LSQ/ROB index).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; state clears while reset==0.
- alloc_valid  in  1  miss request present.
- alloc_addr  in  32  miss byte address (ADDR).
- alloc_is_store  in  1  miss is a store.
- alloc_st_size  in  2  store size (MEM_SIZE).
- alloc_data  in  32  store data (DATA).
- alloc_id  in  ID_WIDTH  requester id.
- alloc_ready  out  1  entry will be accepted this cycle.
- proc2mem_command  out  2  MEM_NONE or MEM_LOAD.
- proc2mem_addr  out  32  request address, low 3 bits zero.
- mem2proc_transaction_tag  in  4  nonzero = request accepted with this tag.
- mem2proc_data  in  64  returned block (MEM_BLOCK).
- mem2proc_data_tag  in  4  nonzero = mem2proc_data valid for this tag.
- mshr2Dcache_wr  out  1  fill pulse.
- mshr2Dcache_mem_block  out  64  fill block.
- mshr2Dcache_addr  out  32  original miss byte address.
- mshr2Dcache_is_store, mshr2Dcache_st_size, mshr2Dcache_data, mshr2Dcache_id  out  1/2/32/ID_WIDTH  original request fields.
- mshr_empty  out  1  no entries valid.

Behaviour:
- Entry states: FREE → PENDING (allocated, not yet accepted by memory) → WAIT (holds mem tag) → FREE on fill.
- Allocation:
  - alloc_ready = (any FREE entry) && !(any non-FREE entry with addr[31:3]==alloc_addr[31:3]).
  - Same-block secondary misses are refused; the requester retries.
  - Computed from registered state only, so an entry freed this cycle is reusable next cycle.
  - On alloc_valid && alloc_ready, the lowest-index FREE entry captures all alloc_* fields and becomes PENDING at the next edge.
- Issue:
  - The lowest-index PENDING entry drives proc2mem_command=MEM_LOAD and proc2mem_addr={addr[31:3],3'b0}. Otherwise MEM_NONE and address 0.
  - An entry allocated this cycle is not issued until next cycle (no bypass).
  - If mem2proc_transaction_tag != 0 in the issue cycle, the entry stores the tag and becomes WAIT.
  - If the tag is 0, the entry stays PENDING and reissues next cycle.
- Return:
  - When mem2proc_data_tag != 0 and equals the tag of a WAIT entry, that entry frees at the next edge.
  - On that same edge the fill outputs register: mshr2Dcache_wr=1, block=mem2proc_data, plus the entry's stored addr/is_store/st_size/data/id.
  - Fill latency is 1 cycle after data_tag, pulse width is exactly 1 cycle, and the cache accepts unconditionally.
  - A data tag matching no WAIT entry is ignored.
  - If the transaction tag and data tag of the same cycle are equal, the return is processed first and the issuing entry records the tag normally.
- Tag uniqueness among WAIT entries is guaranteed by memory.
- When not filling, all mshr2Dcache_* outputs are 0.
- Reset (reset==0, asynchronous) produces:
  - All entries FREE, all tags 0.
  - mshr2Dcache_wr=0 and all fill outputs 0.
  - proc2mem_command=MEM_NONE.
  - alloc_ready=1, mshr_empty=1.
  - Reset mid-flight discards outstanding misses; late data tags after release find no match.
- Full: with all entries non-FREE, alloc_ready=0. It rises the cycle after a fill frees an entry.

Optional Feature:
- Macro DCACHE_MSHR_STATS_EN.
- Defined: adds outputs stat_misses (32), stat_full_stalls (32), stat_retries (32). All reset to 0 and wrap at 2^32.
  - stat_misses: +1 per accepted allocation.
  - stat_full_stalls: +1 per cycle with alloc_valid && !alloc_ready.
  - stat_retries: +1 per MEM_LOAD cycle with a zero transaction tag.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Alloc load 0x1004, id 3; memory returns transaction tag 2 on the issue cycle, then data_tag 2 with 0xDEADBEEF_01234567 three cycles later → exactly one MEM_LOAD to 0x1000. One cycle after data_tag: mshr2Dcache_wr=1, block 0xDEADBEEF_01234567, addr 0x1004, id 3. mshr_empty=1 afterward.
- Issue with transaction tag 0 for 2 cycles then 5 → MEM_LOAD to the same address for 3 consecutive cycles; entry WAIT with tag 5 (stat_retries=2 when enabled).
- Allocate 0x2000, 0x3008, 0x4010, 0x5018 → alloc_ready=0. A fifth request at 0x6000 is refused until one cycle after the first fill.
- Alloc 0x2000, then alloc 0x2004 → alloc_ready=0 for the second until 0x2000 fills. The retry then allocates and issues a new MEM_LOAD 0x2000.
- Store miss 0x7006, HALF, data 0xBEEF; return tags out of order across two entries (tags 1, 2 returned as 2, 1) → fills appear in return order with correct addr/id/st_size/data per entry.
- Drive reset=0 with two WAIT entries, release, then data_tag of an old tag → no fill, mshr_empty=1, proc2mem_command=MEM_NONE.
